abs_diff_arb: RTL and testbench
===============================

ABS_DIFF_ARB -- requirements
Module: abs_diff_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 3, operand width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters; IDW = max(1, clog2(NUM_REQ)).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  NUM_REQ  per-requester request valid.
REQ-006 SHALL have port req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 SHALL have port req_a  in  NUM_REQ*WIDTH  unsigned operand A; requester i in slice [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_b  in  NUM_REQ*WIDTH  unsigned operand B; same packing.
REQ-009 SHALL have port res_valid  out  1  result register holds a valid result.
REQ-010 SHALL have port res_ready  in  1  downstream accepts result.
REQ-011 SHALL have port res_data  out  RW  |A-B|; RW = WIDTH (RW = WIDTH+8 when the REQ-027 feature is compiled in).
REQ-012 SHALL have port res_agtb  out  1  1 when A > B for the issued request.
REQ-013 SHALL have port res_id  out  IDW  index of the requester that produced the result.

Function
REQ-014 SHALL share one combinational absolute-difference datapath among all requesters.
REQ-015 SHALL use a two-state FSM: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-016 SHALL issue when can_issue = EMPTY, or FULL with res_ready=1, and any req_valid is high.
REQ-017 SHALL grant round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant updates only on issue.
REQ-018 SHALL drive req_ready[i] combinationally = can_issue & grant[i]; a handshake is req_valid[i] & req_ready[i].
REQ-019 SHALL register the result on the issuing edge: 1-cycle latency from handshake to res_valid.
REQ-020 SHALL transition EMPTY->FULL on issue; FULL->EMPTY on res_ready without issue; FULL->FULL on simultaneous drain and issue (full throughput, one result per cycle).
REQ-021 SHALL hold res_data, res_agtb and res_id stable while res_valid=1 and res_ready=0.
REQ-022 SHALL produce res_data=0, res_agtb=0 when A=B; no overflow, since |A-B| <= 2^WIDTH-1.
REQ-023 SHALL never drop or duplicate a request; an ungranted requester keeps req_valid and operands stable (requester obligation, asserted in bench).

Reset
REQ-024 SHALL, on rst_n low, asynchronously force FSM=EMPTY, res_valid=0, res_data=0, res_agtb=0, res_id=0, last_grant=NUM_REQ-1 (first grant goes to requester 0).
REQ-025 SHALL drive req_ready all-zero while rst_n is low.
REQ-026 SHALL discard an in-flight result on reset mid-operation; no issue occurs on the edge where rst_n deasserts.

Configuration
REQ-027 SHALL, with macro ABS_DIFF_ARB_SAD_EN defined, add port req_first (in, NUM_REQ) and one RW-bit accumulator per requester: on issue, acc[i] = (req_first[i] ? 0 : acc[i]) + |A-B|, saturating at 2^RW-1; res_data = the new acc[i]; accumulators reset to 0.
REQ-028 SHALL, without ABS_DIFF_ARB_SAD_EN, have no req_first port and no accumulators; res_data = |A-B| of the issued request.

Structure
REQ-029 SHALL place the FSM state enum (EMPTY, FULL) and the default WIDTH and NUM_REQ constants in shared package abs_diff_pkg.
REQ-030 SHALL instantiate the datapath as sub-module abs_diff_core (inputs a, b; outputs diff, agtb), purely combinational.

Verification
REQ-031 SHALL cover single request: req0 A=5, B=2 -> next cycle res_valid=1, res_data=3, res_agtb=1, res_id=0.
REQ-032 SHALL cover round-robin fairness: all four valid continuously, res_ready=1 -> res_id sequence 0,1,2,3,0; one result per cycle.
REQ-033 SHALL cover backpressure: res_ready=0 for 3 cycles with FULL -> req_ready all 0, outputs stable; res_ready=1 -> drain and the next issue occur in the same cycle.
REQ-034 SHALL cover boundaries: A=0, B=7 -> res_data=7, res_agtb=0; A=B=4 -> res_data=0, res_agtb=0.
REQ-035 SHALL cover reset mid-operation: rst_n low while FULL -> res_valid=0 immediately; after release, first grant goes to req0.
REQ-036 SHALL cover ABS_DIFF_ARB_SAD_EN: req2 pairs (1,4) with first=1, then (6,3), then (7,0) -> res_data 3, 6, 13; the next pair with first=1 -> res_data restarts from |A-B|.

Source files
------------

// File: rtl/abs_diff_pkg.sv
// Shared definitions for the abs_diff_arb block.
//   - Result-register FSM state type (EMPTY / FULL).
//   - Default operand width and requester count.
//   - id_width(): requester-index width, never less than one bit.
package abs_diff_pkg;

  localparam int unsigned DefWidth  = 3;
  localparam int unsigned DefNumReq = 4;

  // EMPTY: result register idle (res_valid=0); FULL: result held (res_valid=1).
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/abs_diff_core.sv
// Purely combinational absolute-difference datapath shared by all requesters.
// Ports:
//   a, b  : unsigned operands, WIDTH bits
//   diff  : |a - b|, WIDTH bits (cannot overflow)
//   agtb  : 1 when a > b (0 when a == b)
module abs_diff_core
  import abs_diff_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             agtb
);

  always_comb begin
    agtb = (a > b);
    diff = agtb ? (a - b) : (b - a);
  end

endmodule

// File: rtl/abs_diff_arb.sv
// Round-robin arbiter in front of one shared |A-B| datapath, with a single
// registered result slot (full throughput: drain and issue in the same cycle).
//
// Optional feature (macro ABS_DIFF_ARB_SAD_EN): per-requester saturating
// sum-of-absolute-differences accumulators; adds input req_first and widens
// res_data to WIDTH+8 bits.
//
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   req_valid     : per-requester request valid
//   req_ready     : per-requester accept (at most one bit high)
//   req_a, req_b  : packed operands, requester i in [i*WIDTH +: WIDTH]
//   req_first     : (SAD only) restart requester's accumulator on issue
//   res_valid     : result register holds a valid result
//   res_ready     : downstream accepts result
//   res_data      : |A-B| (or accumulated sum in SAD mode)
//   res_agtb      : A > B for the issued request
//   res_id        : index of the requester that produced the result
module abs_diff_arb
  import abs_diff_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned NUM_REQ = DefNumReq,
  localparam int unsigned IDW    = id_width(NUM_REQ),
`ifdef ABS_DIFF_ARB_SAD_EN
  localparam int unsigned RW     = WIDTH + 8
`else
  localparam int unsigned RW     = WIDTH
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
`ifdef ABS_DIFF_ARB_SAD_EN
  input  logic [NUM_REQ-1:0]       req_first,
`endif
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RW-1:0]            res_data,
  output logic                     res_agtb,
  output logic [IDW-1:0]           res_id
);

  arb_state_e       state_q;
  logic             active_q;     // low on the first edge after reset release
  logic [IDW-1:0]   last_grant_q;
  logic [RW-1:0]    res_data_q;
  logic             res_agtb_q;
  logic [IDW-1:0]   res_id_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic               can_issue;
  logic               issue;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH-1:0]   diff;
  logic               agtb;
  logic [RW-1:0]      res_next;

  // Rotating priority search starting just after the last granted requester.
  always_comb begin
    int unsigned idx_full;
    logic [IDW-1:0] idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx_full = 0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_full = (32'(last_grant_q) + 32'd1 + k) % NUM_REQ;
      idx      = IDW'(idx_full);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  // active_q blocks issue during reset and on the release edge.
  assign can_issue = active_q & ((state_q == EMPTY) | res_ready);
  assign issue     = can_issue & (|req_valid);
  assign req_ready = can_issue ? grant : '0;

  // One-hot operand mux driven by the grant vector.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  abs_diff_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a    (a_sel),
    .b    (b_sel),
    .diff (diff),
    .agtb (agtb)
  );

`ifdef ABS_DIFF_ARB_SAD_EN
  logic [RW-1:0] acc_q [NUM_REQ];
  logic [RW-1:0] acc_base;
  logic [RW:0]   acc_sum;
  logic [RW-1:0] acc_new;

  always_comb begin
    logic first_sel;
    acc_base  = '0;
    first_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        acc_base  = acc_q[i];
        first_sel = req_first[i];
      end
    end
    if (first_sel) begin
      acc_base = '0;
    end
    acc_sum  = {1'b0, acc_base} + (RW+1)'(diff);
    acc_new  = acc_sum[RW] ? '1 : acc_sum[RW-1:0];
    res_next = acc_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (issue && grant[i]) begin
          acc_q[i] <= acc_new;
        end
      end
    end
  end
`else
  assign res_next = diff;
`endif

  // Result-slot FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      active_q     <= 1'b0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      res_data_q   <= '0;
      res_agtb_q   <= 1'b0;
      res_id_q     <= '0;
    end else begin
      active_q <= 1'b1;
      unique case (state_q)
        EMPTY: if (issue) state_q <= FULL;
        FULL:  if (res_ready && !issue) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (issue) begin
        res_data_q   <= res_next;
        res_agtb_q   <= agtb;
        res_id_q     <= grant_id;
        last_grant_q <= grant_id;
      end
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_data  = res_data_q;
  assign res_agtb  = res_agtb_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_abs_diff_arb.sv
// Directed self-checking bench for abs_diff_arb (WIDTH=3, NUM_REQ=4).
module tb_abs_diff_arb;

  localparam int WIDTH   = 3;
  localparam int NUM_REQ = 4;
`ifdef ABS_DIFF_ARB_SAD_EN
  localparam int RW = WIDTH + 8;
`else
  localparam int RW = WIDTH;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
`ifdef ABS_DIFF_ARB_SAD_EN
  logic [NUM_REQ-1:0]       req_first;
`endif
  logic                     res_valid;
  logic                     res_ready;
  logic [RW-1:0]            res_data;
  logic                     res_agtb;
  logic [1:0]               res_id;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  abs_diff_arb #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef ABS_DIFF_ARB_SAD_EN
    .req_first (req_first),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_agtb  (res_agtb),
    .res_id    (res_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic v, input int d, input logic g,
                           input int id);
    chk({tag, ".valid"}, 32'(res_valid), 32'(v));
    chk({tag, ".data"},  32'(res_data),  32'(d));
    chk({tag, ".agtb"},  32'(res_agtb),  32'(g));
    chk({tag, ".id"},    32'(res_id),    32'(id));
  endtask

  task automatic chk_ready(input string tag, input logic [NUM_REQ-1:0] exp);
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp));
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_id   [5] = '{0, 1, 2, 3, 0};
  int exp_data [4] = '{6, 3, 0, 7};
  int exp_agtb [4] = '{1, 0, 0, 0};

  initial begin
    rst_n     = 1'b0;
    res_ready = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
`ifdef ABS_DIFF_ARB_SAD_EN
    req_first = '0;
`endif
    // Round-robin operands; req2 is the A=B case, req3 the A=0,B=7 case.
    set_req(0, 7, 1);
    set_req(1, 2, 5);
    set_req(2, 4, 4);
    set_req(3, 0, 7);
    #2;
    check_res("reset", 1'b0, 0, 1'b0, 0);
    chk_ready("reset", 4'b0000);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("release_no_issue.valid", 32'(res_valid), 32'd0);
    chk_ready("rr_first", 4'b0001);

    // Fairness with all requesters valid and full throughput.
    for (int k = 0; k < 5; k++) begin
      tick();
      check_res($sformatf("rr%0d", k), 1'b1, exp_data[exp_id[k]],
                exp_agtb[exp_id[k]] != 0, exp_id[k]);
    end
    req_valid = 4'h0;
    tick();
    chk("rr_drain.valid", 32'(res_valid), 32'd0);

    // Single request on requester 0.
    set_req(0, 5, 2);
    req_valid = 4'b0001;
    #1;
    chk_ready("single", 4'b0001);
    tick();
    req_valid = 4'h0;
    check_res("single", 1'b1, 3, 1'b1, 0);
    tick();
    chk("single_drain.valid", 32'(res_valid), 32'd0);

    // Backpressure: slot stays FULL, nothing accepted, outputs stable.
    res_ready = 1'b0;
    set_req(1, 6, 1);
    req_valid = 4'b0010;
    #1;
    chk_ready("bp_issue", 4'b0010);
    tick();
    req_valid = 4'h0;
    check_res("bp_first", 1'b1, 5, 1'b1, 1);
    set_req(2, 3, 6);
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_ready($sformatf("bp_hold%0d", k), 4'b0000);
      tick();
      check_res($sformatf("bp_hold%0d", k), 1'b1, 5, 1'b1, 1);
    end
    res_ready = 1'b1;
    #1;
    chk_ready("bp_release", 4'b0100);
    tick();
    req_valid = 4'h0;
    check_res("bp_next", 1'b1, 3, 1'b0, 2);
    tick();
    chk("bp_drain.valid", 32'(res_valid), 32'd0);

    // Reset while FULL.
    res_ready = 1'b0;
    set_req(0, 1, 0);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'h0;
    check_res("pre_rst", 1'b1, 1, 1'b1, 0);
    req_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    check_res("mid_rst", 1'b0, 0, 1'b0, 0);
    chk_ready("mid_rst", 4'b0000);
    @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    tick();
    chk("rst2_no_issue.valid", 32'(res_valid), 32'd0);
    chk_ready("rst2_first", 4'b0001);
    tick();
    req_valid = 4'h0;
    check_res("rst2_grant", 1'b1, 1, 1'b1, 0);
    tick();
    chk("rst2_drain.valid", 32'(res_valid), 32'd0);

`ifdef ABS_DIFF_ARB_SAD_EN
    // Accumulation on requester 2, then restart with req_first.
    req_first = 4'b0100;
    set_req(2, 1, 4);
    req_valid = 4'b0100;
    tick();
    check_res("sad0", 1'b1, 3, 1'b0, 2);
    req_first = 4'b0000;
    set_req(2, 6, 3);
    tick();
    check_res("sad1", 1'b1, 6, 1'b1, 2);
    set_req(2, 7, 0);
    tick();
    check_res("sad2", 1'b1, 13, 1'b1, 2);
    req_first = 4'b0100;
    set_req(2, 2, 7);
    tick();
    req_valid = 4'h0;
    check_res("sad3", 1'b1, 5, 1'b0, 2);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
